// File: rtl/altair_io_pkg.sv
// Shared constants and types for the Altair I/O port sequencer.
// Port map, slot/state encodings and the floating-bus read value.
package altair_io_pkg;

  localparam logic [7:0] SS_PORT       = 8'hFF;
  localparam logic [7:0] SIO_CTRL_PORT = 8'h10;
  localparam logic [7:0] SIO_DATA_PORT = 8'h11;
  localparam logic [7:0] FLOAT_BUS     = 8'hFF;

  typedef enum logic [1:0] {
    SLOT_NONE,
    SLOT_SS,
    SLOT_SIO
  } slot_e;

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    WAIT,
    DONE
  } state_e;

  // Request fields that must persist past the acceptance cycle.
  typedef struct packed {
    logic  wr;
    slot_e slot;
  } io_req_t;

endpackage

// File: rtl/io_port_decode.sv
// Combinational port-number decode: selects the device slot and,
// for the 2SIO board, which of its two registers is addressed.
module io_port_decode
  import altair_io_pkg::*;
(
  input  logic [7:0] port,
  output slot_e      slot,
  output logic       sio_addr
);

  always_comb begin
    slot     = SLOT_NONE;
    sio_addr = 1'b0;
    case (port)
      SS_PORT:       slot = SLOT_SS;
      SIO_CTRL_PORT: slot = SLOT_SIO;
      SIO_DATA_PORT: begin
        slot     = SLOT_SIO;
        sio_addr = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/io_port_ctrl.sv
// 8080 IN/OUT cycle sequencer: one request at a time, strobes the decoded
// device, waits on fixed latency or ready/timeout, then pulses io_done.
module io_port_ctrl
  import altair_io_pkg::*;
#(
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       io_req,
  input  logic       io_wr,
  input  logic [7:0] io_port,
  input  logic [7:0] io_wdata,
  output logic       io_busy,
  output logic       io_done,
  output logic [7:0] io_rdata,
  output logic       io_timeout,
  output logic       ss_rd,
  input  logic [7:0] ss_data,
  output logic       sio_rd,
  output logic       sio_wr,
  output logic       sio_addr,
  output logic [7:0] sio_wdata,
  input  logic [7:0] sio_rdata,
  input  logic       sio_ready
);

  localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e     state;
  io_req_t    req;
  logic [2:0] wait_cnt;
  logic [7:0] tmo_cnt;
  slot_e      dec_slot;
  logic       dec_addr;

  io_port_decode u_decode (
    .port     (io_port),
    .slot     (dec_slot),
    .sio_addr (dec_addr)
  );

  // Strobes are launched on the acceptance edge so they are registered
  // and high exactly during the STROBE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req        <= '{wr: 1'b0, slot: SLOT_NONE};
      wait_cnt   <= '0;
      tmo_cnt    <= '0;
      io_busy    <= 1'b0;
      io_done    <= 1'b0;
      io_timeout <= 1'b0;
      io_rdata   <= FLOAT_BUS;
      ss_rd      <= 1'b0;
      sio_rd     <= 1'b0;
      sio_wr     <= 1'b0;
      sio_addr   <= 1'b0;
      sio_wdata  <= 8'h00;
    end else begin
      ss_rd      <= 1'b0;
      sio_rd     <= 1'b0;
      sio_wr     <= 1'b0;
      io_done    <= 1'b0;
      io_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (io_req) begin
            req     <= '{wr: io_wr, slot: dec_slot};
            io_busy <= 1'b1;
            state   <= STROBE;
            case (dec_slot)
              SLOT_SS:  ss_rd <= ~io_wr;
              SLOT_SIO: begin
                sio_rd    <= ~io_wr;
                sio_wr    <= io_wr;
                sio_addr  <= dec_addr;
                sio_wdata <= io_wdata;
              end
              default: ;
            endcase
          end
        end
        STROBE: begin
          case (req.slot)
            SLOT_SS: begin
              if (req.wr) begin
                io_done <= 1'b1;
                state   <= DONE;
              end else begin
                wait_cnt <= RD_LAT_C;
                state    <= WAIT;
              end
            end
            SLOT_SIO: begin
              tmo_cnt <= '0;
              state   <= WAIT;
            end
            default: begin
              if (!req.wr) io_rdata <= FLOAT_BUS;
              io_done <= 1'b1;
              state   <= DONE;
            end
          endcase
        end
        WAIT: begin
          if (req.slot == SLOT_SS) begin
            wait_cnt <= wait_cnt - 3'd1;
            if (wait_cnt == 3'd1) begin
              io_rdata <= ss_data;
              io_done  <= 1'b1;
              state    <= DONE;
            end
          end else if (sio_ready) begin
            // Ready wins over a timeout expiring in the same cycle.
            if (!req.wr) io_rdata <= sio_rdata;
            io_done <= 1'b1;
            state   <= DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            if (!req.wr) io_rdata <= FLOAT_BUS;
            io_done    <= 1'b1;
            io_timeout <= 1'b1;
            state      <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        DONE: begin
          io_busy <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Bench for io_port_ctrl: completions are scored against a queue of
// expected (rdata, timeout, completion cycle) entries.
module tb_io_port_ctrl;

  logic       clk = 1'b0;
  logic       reset, io_req, io_wr, sio_ready;
  logic [7:0] io_port, io_wdata, ss_data, sio_rdata;
  logic       io_busy, io_done, io_timeout, ss_rd, sio_rd, sio_wr, sio_addr;
  logic [7:0] io_rdata, sio_wdata;

  typedef struct {
    logic [7:0] rdata;
    logic       tmo;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0, errors = 0, cyc = 0;
  int n_ss, n_sr, n_sw, n_done;

  io_port_ctrl #(.RD_LAT(1), .TIMEOUT(15)) dut (
    .clk, .reset, .io_req, .io_wr, .io_port, .io_wdata,
    .io_busy, .io_done, .io_rdata, .io_timeout,
    .ss_rd, .ss_data, .sio_rd, .sio_wr, .sio_addr, .sio_wdata,
    .sio_rdata, .sio_ready
  );

  always #5 clk = ~clk;

  // Score completions mid-cycle; also count strobes for the tests.
  always @(negedge clk) begin
    if (ss_rd)  n_ss++;
    if (sio_rd) n_sr++;
    if (sio_wr) n_sw++;
    if (io_done) begin
      n_done++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected cyc=%0d rdata=%h", cyc, io_rdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (io_rdata !== e.rdata || io_timeout !== e.tmo || cyc != e.cyc) begin
          errors++;
          $display("FAIL done cyc=%0d/%0d rdata=%h/%h tmo=%b/%b",
                   cyc, e.cyc, io_rdata, e.rdata, io_timeout, e.tmo);
        end
      end
    end
  end

  task tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task clr_cnt;
    n_ss = 0; n_sr = 0; n_sw = 0; n_done = 0;
  endtask

  // Drive a one-cycle request in the current cycle (cycle 0); returns in cycle 1.
  task issue(input logic wr, input logic [7:0] port, input logic [7:0] wdata);
    io_req = 1'b1; io_wr = wr; io_port = port; io_wdata = wdata;
    tick;
    io_req = 1'b0;
  endtask

  task drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task test_reset;
    reset = 1'b1;
    tick; tick;
    checks += 3;
    if ({io_busy, io_done, io_timeout, ss_rd, sio_rd, sio_wr, sio_addr} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctl got=%b required=0000000",
               {io_busy, io_done, io_timeout, ss_rd, sio_rd, sio_wr, sio_addr});
    end
    if (sio_wdata !== 8'h00) begin
      errors++; $display("FAIL reset_wdata got=%h required=00", sio_wdata);
    end
    if (io_rdata !== 8'hFF) begin
      errors++; $display("FAIL reset_rdata got=%h required=ff", io_rdata);
    end
    reset = 1'b0;
    tick;
  endtask

  task test_ss_read;
    clr_cnt;
    ss_data = 8'hFD;
    sb.push_back('{8'hFD, 1'b0, cyc + 3});
    issue(1'b0, 8'hFF, 8'h00);
    checks += 2;
    if (ss_rd !== 1'b1 || io_busy !== 1'b1) begin
      errors++; $display("FAIL ss_c1 ss_rd=%b busy=%b required=1 1", ss_rd, io_busy);
    end
    tick;
    if (ss_rd !== 1'b0 || io_busy !== 1'b1) begin
      errors++; $display("FAIL ss_c2 ss_rd=%b busy=%b required=0 1", ss_rd, io_busy);
    end
    drain(20);
    checks++;
    if (n_ss != 1 || n_sr + n_sw != 0 || n_done != 1) begin
      errors++;
      $display("FAIL ss_counts ss=%0d sio=%0d done=%0d required=1 0 1", n_ss, n_sr + n_sw, n_done);
    end
  endtask

  task test_sio_write;
    clr_cnt;
    sb.push_back('{8'hFD, 1'b0, cyc + 5});
    issue(1'b1, 8'h11, 8'h41);
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) sio_ready = 1'b1;
      checks++;
      if (sio_addr !== 1'b1 || sio_wdata !== 8'h41) begin
        errors++;
        $display("FAIL sio_hold c%0d addr=%b wdata=%h required=1 41", k, sio_addr, sio_wdata);
      end
      checks++;
      if (sio_wr !== (k == 1)) begin
        errors++; $display("FAIL sio_wr_c%0d got=%b required=%b", k, sio_wr, k == 1);
      end
      tick;
    end
    sio_ready = 1'b0;
    drain(20);
    checks++;
    if (n_sw != 1 || n_sr != 0 || n_ss != 0) begin
      errors++; $display("FAIL sio_wr_count wr=%0d rd=%0d ss=%0d required=1 0 0", n_sw, n_sr, n_ss);
    end
  endtask

  task test_timeout;
    clr_cnt;
    sb.push_back('{8'hFF, 1'b1, cyc + 17});
    issue(1'b0, 8'h10, 8'h00);
    checks++;
    if (sio_rd !== 1'b1 || sio_addr !== 1'b0) begin
      errors++; $display("FAIL tmo_strobe rd=%b addr=%b required=1 0", sio_rd, sio_addr);
    end
    drain(40);
    // Ready in the expiry cycle is a success.
    sio_rdata = 8'h5A;
    sb.push_back('{8'h5A, 1'b0, cyc + 17});
    issue(1'b0, 8'h10, 8'h00);
    repeat (15) tick;
    sio_ready = 1'b1;
    tick;
    sio_ready = 1'b0;
    drain(20);
    checks++;
    if (n_sr != 2 || n_done != 2) begin
      errors++; $display("FAIL tmo_counts rd=%0d done=%0d required=2 2", n_sr, n_done);
    end
  endtask

  task test_unmapped;
    clr_cnt;
    sb.push_back('{8'h5A, 1'b0, cyc + 2});
    issue(1'b1, 8'hFF, 8'h77);
    drain(20);
    sb.push_back('{8'hFF, 1'b0, cyc + 2});
    issue(1'b0, 8'h42, 8'h00);
    drain(20);
    sb.push_back('{8'hFF, 1'b0, cyc + 2});
    issue(1'b1, 8'h42, 8'h99);
    drain(20);
    checks++;
    if (n_ss + n_sr + n_sw != 0 || n_done != 3) begin
      errors++;
      $display("FAIL unmapped_counts strobes=%0d done=%0d required=0 3", n_ss + n_sr + n_sw, n_done);
    end
  endtask

  task test_ignore;
    clr_cnt;
    ss_data = 8'hC3;
    sb.push_back('{8'hC3, 1'b0, cyc + 3});
    issue(1'b0, 8'hFF, 8'h00);
    for (int k = 1; k <= 3; k++) begin
      io_req = 1'b1;
      io_wr = k[0];
      io_port = (k == 2) ? 8'h10 : 8'hFF;
      tick;
    end
    io_req = 1'b0;
    drain(20);
    repeat (6) tick;
    checks++;
    if (n_done != 1 || n_ss != 1 || n_sr + n_sw != 0) begin
      errors++;
      $display("FAIL ignore_counts done=%0d ss=%0d sio=%0d required=1 1 0", n_done, n_ss, n_sr + n_sw);
    end
  endtask

  task test_back_to_back;
    clr_cnt;
    ss_data = 8'h11;
    sb.push_back('{8'h11, 1'b0, cyc + 3});
    sb.push_back('{8'h22, 1'b0, cyc + 7});
    io_req = 1'b1; io_wr = 1'b0; io_port = 8'hFF;
    for (int k = 0; k <= 4; k++) begin
      if (k == 4) ss_data = 8'h22;
      tick;
    end
    io_req = 1'b0;
    drain(20);
    checks++;
    if (n_done != 2 || n_ss != 2) begin
      errors++; $display("FAIL b2b_counts done=%0d ss=%0d required=2 2", n_done, n_ss);
    end
  endtask

  task test_reset_mid;
    clr_cnt;
    issue(1'b1, 8'h11, 8'hA5);
    tick; tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks += 3;
    if ({io_busy, io_done, io_timeout, ss_rd, sio_rd, sio_wr, sio_addr} !== 7'b0) begin
      errors++;
      $display("FAIL midrst_ctl got=%b required=0000000",
               {io_busy, io_done, io_timeout, ss_rd, sio_rd, sio_wr, sio_addr});
    end
    if (sio_wdata !== 8'h00) begin
      errors++; $display("FAIL midrst_wdata got=%h required=00", sio_wdata);
    end
    if (io_rdata !== 8'hFF) begin
      errors++; $display("FAIL midrst_rdata got=%h required=ff", io_rdata);
    end
    repeat (20) tick;
    checks++;
    if (n_done != 0 || n_sw != 1) begin
      errors++; $display("FAIL midrst_counts done=%0d wr=%0d required=0 1", n_done, n_sw);
    end
    ss_data = 8'h5C;
    sb.push_back('{8'h5C, 1'b0, cyc + 3});
    issue(1'b0, 8'hFF, 8'h00);
    drain(20);
    checks++;
    if (n_done != 1 || n_ss != 1) begin
      errors++; $display("FAIL midrst_after done=%0d ss=%0d required=1 1", n_done, n_ss);
    end
  endtask

  initial begin
    reset = 1'b1; io_req = 1'b0; io_wr = 1'b0; io_port = 8'h00; io_wdata = 8'h00;
    ss_data = 8'h00; sio_rdata = 8'h00; sio_ready = 1'b0;
    clr_cnt;
    test_reset;
    test_ss_read;
    test_sio_write;
    test_timeout;
    test_unmapped;
    test_ignore;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_port_ctrl.md
# io_port_ctrl

Sequencer for 8080 IN/OUT cycles on the Altair I/O bus. Accepts one port request at a time from the CPU bus interface and decodes the port number to a device slot: sense switches, the 2SIO serial board, or unmapped. It then issues the device's one-cycle read/write strobe, waits for the device's data (fixed latency or ready handshake, with timeout), and returns read data with a one-cycle completion pulse. It sits between the CPU core's I/O bus and the sense-switch and 2SIO blocks.

## Interface
- SS_PORT, 8'hFF: sense-switch port (read-only).
- SIO_CTRL_PORT, 8'h10: 2SIO control/status port.
- SIO_DATA_PORT, 8'h11: 2SIO data port.
- RD_LAT, 1: cycles from `ss_rd` strobe to valid `ss_data`; legal range 1..7.
- TIMEOUT, 15: maximum WAIT cycles for `sio_ready`; legal range 1..255.
- clk  in  1  system clock.
- reset  in  1  reset; synchronous, active-high.
- io_req  in  1  request pulse; sampled only in IDLE.
- io_wr  in  1  1 = OUT (write), 0 = IN (read); captured with `io_req`.
- io_port  in  8  port number; captured with `io_req`.
- io_wdata  in  8  OUT data; captured with `io_req`.
- io_busy  out  1  high from the cycle after acceptance through the DONE cycle.
- io_done  out  1  one-cycle completion pulse.
- io_rdata  out  8  IN result; valid with `io_done`, held until the next `io_done`.
- io_timeout  out  1  high with `io_done` when the 2SIO timed out.
- ss_rd  out  1  one-cycle read strobe to the sense switches.
- ss_data  in  8  sense-switch data.
- sio_rd, sio_wr  out  1  one-cycle 2SIO strobes.
- sio_addr  out  1  0 = control, 1 = data; stable from STROBE through WAIT.
- sio_wdata  out  8  2SIO write data; stable from STROBE through WAIT.
- sio_rdata  in  8  2SIO read data; sampled when `sio_ready` = 1.
- sio_ready  in  1  2SIO completion.

## Operation
- States: IDLE, STROBE, WAIT, DONE.
- IDLE:
  - On `io_req` = 1: latch `io_wr`, `io_port`, `io_wdata`.
  - Decode slot SS, SIO or NONE; go to STROBE.
  - `io_req` outside IDLE is ignored. There is no queueing.
- STROBE:
  - SS read: assert `ss_rd`, load the wait counter with RD_LAT, go to WAIT.
  - SS write: no strobe; go to DONE (write discarded, `io_rdata` unchanged).
  - SIO: assert `sio_rd` or `sio_wr`, drive `sio_addr`/`sio_wdata`, clear the timeout counter, go to WAIT.
  - NONE: no strobe; go to DONE. A NONE read sets `io_rdata` = 8'hFF (floating bus); a NONE write is discarded.
- WAIT for SS: decrement the counter each cycle. When it reaches 0, capture `ss_data` into `io_rdata` and go to DONE.
- WAIT for SIO:
  - Sample `sio_ready` every cycle. If it is 1, go to DONE; on a read, also capture `sio_rdata`.
  - Otherwise increment the timeout counter.
  - After TIMEOUT cycles without ready: go to DONE with `io_timeout` = 1. A timed-out read sets `io_rdata` = 8'hFF.
  - `sio_ready` arriving in the same cycle as expiry counts as success, not timeout.
- DONE: pulse `io_done` (and `io_timeout` if flagged), then return to IDLE.
- Reset (any state): go to IDLE.
  - Reset values: `io_busy`, `io_done`, `io_timeout`, `ss_rd`, `sio_rd`, `sio_wr`, `sio_addr` = 0; `sio_wdata` = 8'h00; `io_rdata` = 8'hFF; counters = 0.
  - A transaction in flight is abandoned with no `io_done`.

## Timing
- Cycle 0 is the `io_req` cycle in IDLE. All outputs are registered.
- STROBE is cycle 1: the strobe is high exactly in cycle 1, and `io_busy` is high from cycle 1.
- SS read: `ss_data` is sampled at the end of cycle 1+RD_LAT, and `io_done` is in cycle 2+RD_LAT (RD_LAT = 1 gives cycle 3).
- SS write / NONE: `io_done` in cycle 2.
- SIO: `sio_ready` is first sampled in cycle 2. Ready first seen in cycle k gives `io_done` in cycle k+1.
- SIO timeout: `io_done` + `io_timeout` in cycle TIMEOUT+2 (TIMEOUT = 15 gives cycle 17).
- `sio_ready` asserted in cycle 1 (the STROBE cycle) is not sampled.
- Earliest next acceptance is the cycle after DONE. Back-to-back IN 0xFF therefore completes every 4 cycles at RD_LAT = 1.

## Structure
- Package `altair_io_pkg`:
  - port constants SS_PORT, SIO_CTRL_PORT, SIO_DATA_PORT;
  - slot enum {SLOT_NONE, SLOT_SS, SLOT_SIO};
  - state enum {IDLE, STROBE, WAIT, DONE};
  - FLOAT_BUS = 8'hFF.
- One combinational sub-module, `io_port_decode`: maps port → slot plus the `sio_addr` bit.
- The FSM, wait counter and timeout counter live in `io_port_ctrl`.

## Test plan
- IN 0xFF with `ss_data` = 8'hFD, RD_LAT = 1 → `ss_rd` high only in cycle 1; `io_done` in cycle 3; `io_rdata` = 8'hFD; `io_timeout` = 0.
- OUT 0x11 with data 8'h41, `sio_ready` high in cycle 4 → `sio_wr` high only in cycle 1; `sio_addr` = 1; `sio_wdata` = 8'h41 through cycle 4; `io_done` in cycle 5.
- IN 0x10 with `sio_ready` never high, TIMEOUT = 15 → `io_done` + `io_timeout` in cycle 17; `io_rdata` = 8'hFF. Repeat with ready arriving in cycle 16 → success, `io_rdata` = `sio_rdata`.
- IN 0x42 → no strobes, `io_done` in cycle 2, `io_rdata` = 8'hFF. OUT 0xFF → no strobes, `io_done` in cycle 2, `io_rdata` unchanged.
- `io_req` pulses in cycles 1–3 during an SS read → ignored: exactly one `io_done`, one `ss_rd`.
- `reset` asserted in cycle 3 of an SIO wait → next cycle IDLE, all outputs at reset values, no `io_done`. A new IN 0xFF after reset completes normally.
